// File: rtl/oam_dma.sv
// Sprite DMA: a CPU write to TRIGGER_ADDR halts the core and copies a 256-byte page into OAM_DATA_ADDR.
// Latency: rdy drops the cycle after the trigger; 513 or 514 busy cycles; no backpressure, one byte every 2 cycles.
module oam_dma #(
  parameter logic [15:0] TRIGGER_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_d_out,
  input  logic        cpu_we,
  input  logic [7:0]  bus_d_in,
  output logic        rdy,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_d_out,
  output logic        dma_we
);

  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

  state_t     state, state_nxt;
  logic       par;
  logic [7:0] page;
  logic [7:0] cnt;
  logic [7:0] data_buf;
  logic       trig;

  assign trig = cpu_we && (cpu_addr == TRIGGER_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      par      <= 1'b0;
      page     <= 8'h00;
      cnt      <= 8'h00;
      data_buf <= 8'h00;
    end else begin
      state <= state_nxt;
      par   <= ~par;
      case (state)
        IDLE: if (trig) begin
          page <= cpu_d_out;
          cnt  <= 8'h00;
        end
        READ:  data_buf <= bus_d_in;
        WRITE: if (cnt != 8'hFF) cnt <= cnt + 8'd1;
        default: ;
      endcase
    end
  end

  // Outputs decode only from registered state, so inputs never reach outputs combinationally.
  always_comb begin
    state_nxt  = state;
    rdy        = 1'b0;
    dma_active = 1'b0;
    dma_addr   = 16'h0000;
    dma_d_out  = 8'h00;
    dma_we     = 1'b0;
    case (state)
      IDLE: begin
        rdy = 1'b1;
        if (trig) state_nxt = HALT;
      end
      // par=1 here means the following cycle is even, which is where reads must land.
      HALT:  state_nxt = par ? READ : ALIGN;
      ALIGN: state_nxt = READ;
      READ: begin
        dma_active = 1'b1;
        dma_addr   = {page, cnt};
        state_nxt  = WRITE;
      end
      WRITE: begin
        dma_active = 1'b1;
        dma_addr   = OAM_DATA_ADDR;
        dma_d_out  = data_buf;
        dma_we     = 1'b1;
        state_nxt  = (cnt == 8'hFF) ? IDLE : READ;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: memory returns low address byte ^ A5, transfers are checked byte by byte.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_d_out;
  logic        cpu_we;
  logic [7:0]  bus_d_in;
  logic        rdy;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic [7:0]  dma_d_out;
  logic        dma_we;

  int n_cmp = 0;
  int n_bad = 0;
  logic tb_par;

  oam_dma dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_d_out  (cpu_d_out),
    .cpu_we     (cpu_we),
    .bus_d_in   (bus_d_in),
    .rdy        (rdy),
    .dma_active (dma_active),
    .dma_addr   (dma_addr),
    .dma_d_out  (dma_d_out),
    .dma_we     (dma_we)
  );

  always #5 clk = ~clk;

  // Single-cycle memory model.
  assign bus_d_in = dma_addr[7:0] ^ 8'hA5;

  // Reference cycle parity: even means tb_par==0.
  always @(posedge clk or posedge rst) begin
    if (rst) tb_par <= 1'b0;
    else     tb_par <= ~tb_par;
  end

  // Issues a CPU write during a cycle of the requested parity; returns at the negedge of the following cycle.
  task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data, input logic want_par);
    @(negedge clk);
    if (tb_par != want_par) @(negedge clk);
    cpu_addr  = addr;
    cpu_d_out = data;
    cpu_we    = 1'b1;
    @(negedge clk);
    cpu_we    = 1'b0;
    cpu_addr  = 16'h0000;
    cpu_d_out = 8'h00;
  endtask

  // Called at the negedge of the first cycle after the trigger; returns at the negedge where rdy is back to 1.
  task automatic check_xfer(input string name, input logic [7:0] page, input int exp_low, input bit inject);
    int low = 0;
    int rd_k = 0;
    int wr_k = 0;
    int cyc = 0;
    n_cmp++;
    if (rdy !== 1'b0 || dma_active !== 1'b0) begin
      n_bad++;
      $display("FAIL %s halt_cycle: rdy=%b dma_active=%b, required rdy=0 dma_active=0", name, rdy, dma_active);
    end
    while (rdy !== 1'b1 && cyc < 600) begin
      low++;
      cpu_we = 1'b0;
      if (dma_active && !dma_we) begin
        n_cmp++;
        if (dma_addr !== {page, rd_k[7:0]} || tb_par !== 1'b0) begin
          n_bad++;
          $display("FAIL %s read_%0d: addr=%h par=%b, required addr=%h par=0", name, rd_k, dma_addr, tb_par, {page, rd_k[7:0]});
        end
        if (inject && rd_k == 10) begin
          cpu_addr  = 16'h4014;
          cpu_d_out = 8'h03;
          cpu_we    = 1'b1;
        end
        rd_k++;
      end
      if (dma_we) begin
        n_cmp++;
        if (dma_addr !== 16'h2004 || dma_d_out !== (wr_k[7:0] ^ 8'hA5) || dma_active !== 1'b1) begin
          n_bad++;
          $display("FAIL %s write_%0d: addr=%h data=%h, required addr=2004 data=%h", name, wr_k, dma_addr, dma_d_out, wr_k[7:0] ^ 8'hA5);
        end
        wr_k++;
      end
      cyc++;
      @(negedge clk);
    end
    cpu_we = 1'b0;
    n_cmp++;
    if (low !== exp_low) begin
      n_bad++;
      $display("FAIL %s rdy_low_cycles: got %0d, required %0d", name, low, exp_low);
    end
    n_cmp++;
    if (rd_k !== 256 || wr_k !== 256) begin
      n_bad++;
      $display("FAIL %s byte_counts: reads=%0d writes=%0d, required 256/256", name, rd_k, wr_k);
    end
    n_cmp++;
    if (dma_active !== 1'b0 || dma_we !== 1'b0 || dma_addr !== 16'h0000) begin
      n_bad++;
      $display("FAIL %s idle_after: active=%b we=%b addr=%h, required 0/0/0000", name, dma_active, dma_we, dma_addr);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cpu_addr = 16'h0000; cpu_d_out = 8'h00; cpu_we = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rdy !== 1'b1 || dma_active !== 1'b0 || dma_we !== 1'b0 || dma_addr !== 16'h0000 || dma_d_out !== 8'h00) begin
        n_bad++;
        $display("FAIL reset_idle_%0d: rdy=%b act=%b we=%b addr=%h d=%h, required 1/0/0/0000/00", i, rdy, dma_active, dma_we, dma_addr, dma_d_out);
      end
    end
  endtask

  task automatic test_other_addr;
    cpu_write(16'h4015, 8'h02, 1'b0);
    n_cmp++;
    if (rdy !== 1'b1 || dma_active !== 1'b0) begin
      n_bad++;
      $display("FAIL non_trigger_write: rdy=%b act=%b, required 1/0", rdy, dma_active);
    end
  endtask

  task automatic test_xfer_even;
    cpu_write(16'h4014, 8'h02, 1'b0);
    check_xfer("xfer_even", 8'h02, 513, 1'b0);
  endtask

  task automatic test_xfer_align;
    cpu_write(16'h4014, 8'h02, 1'b1);
    check_xfer("xfer_align", 8'h02, 514, 1'b0);
  endtask

  task automatic test_page_ff;
    cpu_write(16'h4014, 8'hFF, 1'b0);
    check_xfer("page_ff", 8'hFF, 513, 1'b0);
  endtask

  task automatic test_ignored_trigger;
    cpu_write(16'h4014, 8'h02, 1'b1);
    check_xfer("ignored_trig", 8'h02, 514, 1'b1);
  endtask

  task automatic test_back_to_back;
    cpu_write(16'h4014, 8'h00, 1'b0);
    check_xfer("b2b_first", 8'h00, 513, 1'b0);
    // rdy just returned: the trigger is accepted in this very cycle, which is even.
    cpu_addr = 16'h4014; cpu_d_out = 8'h05; cpu_we = 1'b1;
    @(negedge clk);
    cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_d_out = 8'h00;
    check_xfer("b2b_second", 8'h05, 513, 1'b0);
  endtask

  task automatic test_reset_abort;
    int wr_k = 0;
    int cyc = 0;
    cpu_write(16'h4014, 8'h02, 1'b0);
    while (!(dma_we && wr_k == 100) && cyc < 600) begin
      if (dma_we) wr_k++;
      cyc++;
      @(negedge clk);
    end
    n_cmp++;
    if (!(dma_we === 1'b1 && dma_d_out === (8'd100 ^ 8'hA5))) begin
      n_bad++;
      $display("FAIL abort_reach_byte100: we=%b data=%h, required 1/%h", dma_we, dma_d_out, 8'd100 ^ 8'hA5);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (rdy !== 1'b1 || dma_active !== 1'b0 || dma_we !== 1'b0 || dma_addr !== 16'h0000 || dma_d_out !== 8'h00) begin
      n_bad++;
      $display("FAIL abort_async: rdy=%b act=%b we=%b addr=%h d=%h, required 1/0/0/0000/00", rdy, dma_active, dma_we, dma_addr, dma_d_out);
    end
    @(negedge clk);
    rst = 1'b0;
    cpu_write(16'h4014, 8'h02, 1'b1);
    check_xfer("after_abort", 8'h02, 514, 1'b0);
  endtask

  initial begin
    test_reset;
    test_other_addr;
    test_xfer_even;
    test_xfer_align;
    test_page_ff;
    test_ignored_trigger;
    test_back_to_back;
    test_reset_abort;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
